// File: rtl/cheshire_idma_job_arbiter.sv
// Round-robin job arbiter that shares one iDMA backend between NumReq sources.
// Completions are steered back to their issuer through an in-order tag FIFO.
module cheshire_idma_job_arbiter #(
  parameter int unsigned NumReq      = 4,
  parameter int unsigned JobWidth    = 160,
  parameter int unsigned MaxInFlight = 8,
  parameter int unsigned IdxWidth    = $clog2(NumReq),
  parameter int unsigned CntWidth    = $clog2(MaxInFlight + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NumReq-1:0]          req_valid_i,
  output logic [NumReq-1:0]          req_ready_o,
  input  logic [NumReq*JobWidth-1:0] req_job_i,
  output logic [JobWidth-1:0]        be_job_o,
  output logic                       be_valid_o,
  input  logic                       be_ready_i,
  input  logic                       be_rsp_valid_i,
  input  logic                       be_rsp_error_i,
  output logic                       be_rsp_ready_o,
  output logic [NumReq-1:0]          rsp_valid_o,
  output logic                       rsp_error_o,
  input  logic [NumReq-1:0]          rsp_ready_i,
  output logic [CntWidth-1:0]        inflight_o,
  output logic                       busy_o
);

  localparam int unsigned PtrWidth = (MaxInFlight > 1) ? $clog2(MaxInFlight) : 1;

  logic [IdxWidth-1:0] rr_ptr, locked_idx, rr_idx, cand, grant, head;
  logic                lock, found, full, empty, handshake, pop;
  logic [CntWidth-1:0] inflight;
  logic [PtrWidth-1:0] wr_ptr, rd_ptr;
  logic [IdxWidth-1:0] tag_mem [MaxInFlight];

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    rr_idx = rr_ptr;
    cand   = '0;
    found  = 1'b0;
    for (int k = 0; k < int'(NumReq); k++) begin
      cand = IdxWidth'((int'(rr_ptr) + k) % int'(NumReq));
      if (!found && req_valid_i[cand]) begin
        rr_idx = cand;
        found  = 1'b1;
      end
    end
  end

  assign full       = (inflight == CntWidth'(MaxInFlight));
  assign empty      = (inflight == '0);
  assign grant      = lock ? locked_idx : rr_idx;
  assign be_valid_o = !full && req_valid_i[grant];
  assign be_job_o   = req_job_i[32'(grant) * JobWidth +: JobWidth];
  assign handshake  = be_valid_o && be_ready_i;

  always_comb begin
    req_ready_o = '0;
    if (be_ready_i && !full) req_ready_o[grant] = 1'b1;
  end

  assign head           = tag_mem[rd_ptr];
  assign be_rsp_ready_o = rsp_ready_i[head] && !empty;
  assign rsp_error_o    = be_rsp_error_i;
  assign pop            = be_rsp_valid_i && be_rsp_ready_o;

  always_comb begin
    rsp_valid_o = '0;
    if (be_rsp_valid_i && !empty) rsp_valid_o[head] = 1'b1;
  end

  assign inflight_o = inflight;
  assign busy_o     = !empty || be_valid_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr     <= '0;
      lock       <= 1'b0;
      locked_idx <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      inflight   <= '0;
    end else begin
      if (handshake) begin
        lock   <= 1'b0;
        rr_ptr <= IdxWidth'((int'(grant) + 1) % int'(NumReq));
        wr_ptr <= (wr_ptr == PtrWidth'(MaxInFlight - 1)) ? '0 : wr_ptr + 1'b1;
      end else if (be_valid_o && !be_ready_i) begin
        // Hold the offered job stable until the backend takes it.
        lock       <= 1'b1;
        locked_idx <= grant;
      end
      if (pop) rd_ptr <= (rd_ptr == PtrWidth'(MaxInFlight - 1)) ? '0 : rd_ptr + 1'b1;
      if (handshake && !pop)      inflight <= inflight + 1'b1;
      else if (!handshake && pop) inflight <= inflight - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (handshake) tag_mem[wr_ptr] <= grant;
  end

  a_inflight_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
    inflight <= CntWidth'(MaxInFlight));
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(handshake && full));
  a_rsp_nonempty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(be_rsp_valid_i && empty));
  a_lock_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lock |-> req_valid_i[locked_idx]);

endmodule

// File: tb/tb_cheshire_idma_job_arbiter.sv
// Directed bench for cheshire_idma_job_arbiter: grants and completions are
// checked by negedge monitors against queues filled by the stimulus thread.
module tb_cheshire_idma_job_arbiter;

  localparam int NR = 4;
  localparam int JW = 32;
  localparam int MI = 8;
  localparam int IW = $clog2(NR);
  localparam int CW = $clog2(MI + 1);
  localparam int GW = IW + JW;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NR*JW-1:0] req_job;
  logic [JW-1:0]    be_job;
  logic             be_valid, be_ready, be_rsp_valid, be_rsp_error, be_rsp_ready;
  logic             rsp_error, busy;
  logic [CW-1:0]    inflight;
  logic [JW-1:0]    jobs [NR];

  logic [GW-1:0] exp_q[$];
  logic [IW:0]   exp_rsp_q[$];

  int total = 0;
  int bad   = 0;

  // clock / reset
  always #5 clk = ~clk;

  always_comb begin
    req_job = '0;
    for (int i = 0; i < NR; i++) req_job[i*JW +: JW] = jobs[i];
  end

  cheshire_idma_job_arbiter #(
    .NumReq(NR), .JobWidth(JW), .MaxInFlight(MI)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_job_i(req_job),
    .be_job_o(be_job), .be_valid_o(be_valid), .be_ready_i(be_ready),
    .be_rsp_valid_i(be_rsp_valid), .be_rsp_error_i(be_rsp_error),
    .be_rsp_ready_o(be_rsp_ready), .rsp_valid_o(rsp_valid),
    .rsp_error_o(rsp_error), .rsp_ready_i(rsp_ready),
    .inflight_o(inflight), .busy_o(busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NR-1:0] onehot(input logic [IW-1:0] idx);
    return NR'(1) << idx;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_grant(input int idx, input logic [JW-1:0] job);
    exp_q.push_back({IW'(idx), job});
  endtask

  task automatic push_rsp(input int idx, input logic err);
    exp_rsp_q.push_back({IW'(idx), err});
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    logic [GW-1:0] g;
    logic [IW:0]   r;
    if (rst_n) begin
      if (be_valid && be_ready) begin
        if (exp_q.size() == 0) begin
          check("grant_unexpected", 64'(req_ready), 64'(0));
          check("grant_unexpected_q", 64'(exp_q.size()), 64'(1));
        end else begin
          g = exp_q.pop_front();
          check("grant_ready", 64'(req_ready), 64'(onehot(g[GW-1:JW])));
          check("grant_job", 64'(be_job), 64'(g[JW-1:0]));
        end
      end
      if (be_rsp_valid && be_rsp_ready) begin
        if (exp_rsp_q.size() == 0) begin
          check("rsp_unexpected_q", 64'(exp_rsp_q.size()), 64'(1));
        end else begin
          r = exp_rsp_q.pop_front();
          check("rsp_route", 64'(rsp_valid), 64'(onehot(r[IW:1])));
          check("rsp_error", 64'(rsp_error), 64'(r[0]));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; req_valid = '0; be_ready = 1'b0;
    be_rsp_valid = 1'b0; be_rsp_error = 1'b0; rsp_ready = '0;
    for (int i = 0; i < NR; i++) jobs[i] = '0;

    // reset state
    tick(); tick();
    check("rst_inflight", 64'(inflight), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_be_valid", 64'(be_valid), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_be_rsp_ready", 64'(be_rsp_ready), 64'(0));
    check("rst_rsp_error", 64'(rsp_error), 64'(0));
    rst_n = 1'b1;

    // lock: req1 stalled, req0 joins; rr_ptr=0 would otherwise pick 0
    tick();
    req_valid = 4'b0010; jobs[1] = 32'h201; jobs[0] = 32'h200;
    #1;
    check("lock_valid", 64'(be_valid), 64'(1));
    check("lock_job0", 64'(be_job), 64'(32'h201));
    check("lock_ready0", 64'(req_ready), 64'(0));
    tick();
    check("lock_job1", 64'(be_job), 64'(32'h201));
    tick();
    req_valid = 4'b0011;
    #1;
    check("lock_job2", 64'(be_job), 64'(32'h201));
    check("lock_busy", 64'(busy), 64'(1));
    tick();
    be_ready = 1'b1;
    push_grant(1, 32'h201); push_grant(0, 32'h200);
    #1;
    check("lock_release_ready", 64'(req_ready), 64'(4'b0010));
    tick();
    req_valid = 4'b0001;
    #1;
    check("lock_next_ready", 64'(req_ready), 64'(4'b0001));
    check("lock_next_job", 64'(be_job), 64'(32'h200));
    tick();
    req_valid = '0; be_ready = 1'b0;
    #1;
    check("lock_inflight", 64'(inflight), 64'(2));
    push_rsp(1, 1'b0); push_rsp(0, 1'b0);
    be_rsp_valid = 1'b1; rsp_ready = 4'hF;
    tick(); tick();
    be_rsp_valid = 1'b0;
    #1;
    check("lock_drain", 64'(inflight), 64'(0));

    // single job from requester 2
    tick();
    req_valid = 4'b0100; jobs[2] = 32'hA5; be_ready = 1'b1;
    push_grant(2, 32'hA5);
    #1;
    check("single_valid", 64'(be_valid), 64'(1));
    check("single_job", 64'(be_job), 64'(32'hA5));
    check("single_ready", 64'(req_ready), 64'(4'b0100));
    check("single_inflight0", 64'(inflight), 64'(0));
    tick();
    req_valid = '0;
    #1;
    check("single_inflight1", 64'(inflight), 64'(1));
    be_rsp_valid = 1'b1; rsp_ready = 4'hF;
    push_rsp(2, 1'b0);
    #1;
    check("single_rsp_valid", 64'(rsp_valid), 64'(4'b0100));
    check("single_rsp_ready", 64'(be_rsp_ready), 64'(1));
    tick();
    be_rsp_valid = 1'b0;
    #1;
    check("single_done", 64'(inflight), 64'(0));

    // reset back to rr_ptr=0, then round-robin until full
    tick(); rst_n = 1'b0; be_ready = 1'b0; tick(); rst_n = 1'b1;
    req_valid = 4'hF; be_ready = 1'b1;
    for (int i = 0; i < NR; i++) jobs[i] = 32'h100 + JW'(i);
    for (int i = 0; i < 8; i++) push_grant(i % NR, 32'h100 + JW'(i % NR));
    repeat (8) tick();
    #1;
    check("full_inflight", 64'(inflight), 64'(8));
    check("full_be_valid", 64'(be_valid), 64'(0));
    check("full_req_ready", 64'(req_ready), 64'(0));
    check("full_busy", 64'(busy), 64'(1));
    // retire while full: no grant this cycle
    be_rsp_valid = 1'b1; rsp_ready = 4'hF;
    push_rsp(0, 1'b0);
    #1;
    check("full_retire_nogrant", 64'(be_valid), 64'(0));
    check("full_retire_route", 64'(rsp_valid), 64'(4'b0001));
    tick();
    be_rsp_valid = 1'b0;
    push_grant(0, 32'h100);
    #1;
    check("full_regrant_valid", 64'(be_valid), 64'(1));
    check("full_regrant_ready", 64'(req_ready), 64'(4'b0001));
    tick();
    req_valid = '0;
    #1;
    check("full_refill", 64'(inflight), 64'(8));
    for (int i = 1; i <= 8; i++) push_rsp(i % NR, 1'b0);
    be_rsp_valid = 1'b1;
    repeat (8) tick();
    be_rsp_valid = 1'b0;
    #1;
    check("rr_drain", 64'(inflight), 64'(0));

    // completion backpressure with error, requester 3
    req_valid = 4'b1000; jobs[3] = 32'h3E3; be_ready = 1'b1;
    push_grant(3, 32'h3E3);
    tick();
    req_valid = '0; be_ready = 1'b0;
    be_rsp_valid = 1'b1; be_rsp_error = 1'b1; rsp_ready = '0;
    #1;
    check("bp_ready0", 64'(be_rsp_ready), 64'(0));
    check("bp_route", 64'(rsp_valid), 64'(4'b1000));
    check("bp_error", 64'(rsp_error), 64'(1));
    tick();
    check("bp_ready1", 64'(be_rsp_ready), 64'(0));
    check("bp_hold", 64'(inflight), 64'(1));
    tick();
    rsp_ready = 4'b1000;
    push_rsp(3, 1'b1);
    #1;
    check("bp_release", 64'(be_rsp_ready), 64'(1));
    tick();
    be_rsp_valid = 1'b0; be_rsp_error = 1'b0; rsp_ready = '0;
    #1;
    check("bp_done", 64'(inflight), 64'(0));

    // reset with three jobs in flight
    req_valid = 4'b0111; be_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      jobs[i] = 32'h400 + JW'(i);
      push_grant(i, 32'h400 + JW'(i));
    end
    repeat (3) tick();
    req_valid = '0;
    #1;
    check("mid_inflight", 64'(inflight), 64'(3));
    check("mid_busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_inflight", 64'(inflight), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    req_valid = 4'hF; jobs[3] = 32'h403;
    push_grant(0, 32'h400);
    #1;
    check("mid_rst_grant", 64'(req_ready), 64'(4'b0001));
    tick();
    req_valid = '0; be_ready = 1'b0;
    #1;
    check("mid_rst_inflight1", 64'(inflight), 64'(1));
    push_rsp(0, 1'b0);
    be_rsp_valid = 1'b1; rsp_ready = 4'hF;
    tick();
    be_rsp_valid = 1'b0;
    #1;
    check("mid_rst_drain", 64'(inflight), 64'(0));

    // final report
    tick();
    check("grant_q_empty", 64'(exp_q.size()), 64'(0));
    check("rsp_q_empty", 64'(exp_rsp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
